mul8_seq: RTL and testbench
===========================

# mul8_seq

Sequential 8x8 unsigned multiplier controller built around the existing combinational 4-bit multiplier (Multiplier4b). It accepts an operand pair on a start pulse, computes four nibble partial products over four consecutive cycles through a single shared Multiplier4b instance, and shifts and accumulates them into a 16-bit product. It sits between a requesting datapath and the 4-bit multiplier, and is the only driver of that multiplier's inputs.

## Interface

- Parameters: none; operand width 8, nibble width 4 and product width 16 are fixed.
- Clock and reset: one clock; reset is asynchronous and active-high (ports `clk`, `rst`).
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only when `busy`=0.
- `a`  input  8  multiplicand; captured on an accepted `start`.
- `b`  input  8  multiplier; captured on an accepted `start`.
- `busy`  output  1  high while a multiplication is in progress or finishing.
- `done`  output  1  one-cycle pulse; `p` is valid.
- `p`  output  16  product; holds its value until the next accepted `start`.

## Operation

- States: IDLE, PP0, PP1, PP2, PP3, DONE. `busy` = (state != IDLE).
- IDLE:
  - `start`=1 latches `a` into `a_r` and `b` into `b_r`, clears `acc` to 0, and moves to PP0.
  - Otherwise stays in IDLE and holds `acc`.
- Partial-product states drive the Multiplier4b mode input `c` to 0 (unsigned) in every state. Each state adds `pp` << shift to `acc`:
  - PP0: `a_r[3:0]` x `b_r[3:0]`, shift 0.
  - PP1: `a_r[7:4]` x `b_r[3:0]`, shift 4.
  - PP2: `a_r[3:0]` x `b_r[7:4]`, shift 4.
  - PP3: `a_r[7:4]` x `b_r[7:4]`, shift 8.
- Transitions: PP0 -> PP1 -> PP2 -> PP3 -> DONE, unconditional.
- DONE: `done`=1 for this one cycle; next state is IDLE.
- Arithmetic:
  - Each `pp` is 8 bits, zero-extended to 16 bits before the shift.
  - `acc` is 16 bits. The sum never exceeds 0xFE01, so no overflow handling is required.
- `p` is wired directly to `acc`.
- `start` while `busy`=1, including in DONE, is ignored and does not queue. Operand changes while busy have no effect.
- Signed multiplication is not supported; `c` is never driven to 1.

## Timing

- Reset values: state=IDLE, `busy`=0, `done`=0, `p`=0x0000, `a_r`=`b_r`=0x00.
- Reset mid-operation returns to IDLE immediately (asynchronously). Partial `acc` is cleared to 0 and no `done` is produced.
- Cycle timing for a `start` sampled at edge N:
  - `busy` rises after edge N.
  - Accumulation happens at edges N+1 to N+4.
  - `done`=1 in the cycle between edges N+4 and N+5.
  - `busy` falls after edge N+5.
- Latency: `start` to `done` is 5 cycles. Throughput: one product every 6 cycles, since the earliest next accepted `start` is at edge N+6, with `start` held high after `done`.
- `p` shows intermediate accumulation values while `busy`=1. It is valid only when `done`=1 and while in IDLE afterwards.
- `done` and `busy` are both high in the DONE cycle.

## Structure

- Shared header `mul8_seq_defs.vh` contains:
  - state encoding localparams (3-bit: IDLE=0, PP0=1, PP1=2, PP2=3, PP3=4, DONE=5);
  - width constants OPW=8, NIBW=4, PW=16.
- One sub-module: a single Multiplier4b instance (`u_mul`) fed by a combinational nibble-select mux keyed on state.
- No other hierarchy. Shift and accumulate logic is inline.

## Test plan

- Reset: assert `rst` asynchronously mid-cycle -> `busy`=0, `done`=0, `p`=0x0000 without waiting for a clock edge.
- Basic: `a`=0x12, `b`=0x34, one-cycle `start` -> `done` pulses exactly 5 cycles later, `p`=0x03A8, and `p` holds 0x03A8 in IDLE afterwards.
- Corners: 0xFF x 0xFF -> 0xFE01; 0x00 x 0xAB -> 0x0000; 0x10 x 0x10 -> 0x0100; 0x0F x 0xF0 -> 0x0E10.
- Busy rejection: start 0x03 x 0x07, then pulse `start` with 0xFF x 0xFF at each of PP1 and DONE -> only one `done`, `p`=0x0015.
- Back-to-back: hold `start`=1 continuously with 0x21 x 0x02 -> `done` every 6 cycles, `p`=0x0042 each time; `c` observed 0 throughout.
- Reset mid-operation: `rst` pulse during PP2 -> no `done`, `p`=0x0000. A subsequent 0x05 x 0x05 -> `p`=0x0019.

Source files
------------

// File: rtl/mul8_seq_pkg.sv
// mul8_seq_pkg: state encoding and fixed widths shared by the sequential 8x8 multiplier
package mul8_seq_pkg;
    localparam int OPW  = 8;
    localparam int NIBW = 4;
    localparam int PW   = 16;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        DONE = 3'd5
    } state_e;
endpackage

// File: rtl/mul8_seq_mul4.sv
// Multiplier4b: combinational 4x4 multiplier; c=0 unsigned, c=1 two's-complement signed
module Multiplier4b
    import mul8_seq_pkg::*;
(
    input  logic [NIBW-1:0]   a,
    input  logic [NIBW-1:0]   b,
    input  logic              c,
    output logic [2*NIBW-1:0] p
);
    logic [2*NIBW-1:0] ax, bx;
    // The low 8 bits of a product of sign-extended operands equal the signed product
    always_comb begin
        ax = c ? {{NIBW{a[NIBW-1]}}, a} : {{NIBW{1'b0}}, a};
        bx = c ? {{NIBW{b[NIBW-1]}}, b} : {{NIBW{1'b0}}, b};
        p  = ax * bx;
    end
endmodule

// File: rtl/mul8_seq.sv
// mul8_seq: 8x8 unsigned multiplier built from four nibble products through one shared
// Multiplier4b, accumulated over PP0..PP3 and reported with a one-cycle done pulse.
module mul8_seq
    import mul8_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [PW-1:0]  p
);
    state_e            state_q, state_d;
    logic [OPW-1:0]    a_q, a_d, b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [NIBW-1:0]   mul_a, mul_b;
    logic [2*NIBW-1:0] pp;
    logic [3:0]        sh;
    logic              mul_c;

    Multiplier4b u_mul (
        .a(mul_a),
        .b(mul_b),
        .c(mul_c),
        .p(pp)
    );

    always_comb begin
        mul_c   = 1'b0;
        mul_a   = (state_q == PP1 || state_q == PP3) ? a_q[7:4] : a_q[3:0];
        mul_b   = (state_q == PP2 || state_q == PP3) ? b_q[7:4] : b_q[3:0];
        sh      = (state_q == PP0) ? 4'd0 : (state_q == PP3) ? 4'd8 : 4'd4;
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                acc_d   = '0;
                state_d = PP0;
            end
            PP0: begin
                acc_d   = acc_q + (PW'(pp) << sh);
                state_d = PP1;
            end
            PP1: begin
                acc_d   = acc_q + (PW'(pp) << sh);
                state_d = PP2;
            end
            PP2: begin
                acc_d   = acc_q + (PW'(pp) << sh);
                state_d = PP3;
            end
            PP3: begin
                acc_d   = acc_q + (PW'(pp) << sh);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign p    = acc_q;
endmodule

// File: tb/tb_mul8_seq.sv
// tb_mul8_seq: directed scenarios for mul8_seq with hand-computed products and cycle timing
module tb_mul8_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        busy, done;
    logic [15:0] p;
    int          n_cmp = 0;
    int          n_bad = 0;

    mul8_seq dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .p(p)
    );

    always #5 clk = ~clk;

    // Launch one multiplication and wait (bounded) for done; lat counts negedges from the accepting edge
    task automatic run_mul(input logic [7:0] x, input logic [7:0] y, output int lat, output logic [15:0] prod);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        prod = p;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp += 3;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (p !== 16'h0000) begin n_bad++; $display("FAIL reset_p: got %h want 0000", p); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] prod;
        run_mul(8'h12, 8'h34, lat, prod);
        n_cmp += 2;
        if (lat !== 5) begin n_bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        if (prod !== 16'h03A8) begin n_bad++; $display("FAIL basic_p: got %h want 03a8", prod); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp += 3;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL basic_idle_done: got %b want 0", done); end
        if (p !== 16'h03A8) begin n_bad++; $display("FAIL basic_hold_p: got %h want 03a8", p); end
    endtask

    task automatic test_corners();
        logic [7:0]  xs [4] = '{8'hFF, 8'h00, 8'h10, 8'h0F};
        logic [7:0]  ys [4] = '{8'hFF, 8'hAB, 8'h10, 8'hF0};
        logic [15:0] ex [4] = '{16'hFE01, 16'h0000, 16'h0100, 16'h0E10};
        int lat;
        logic [15:0] prod;
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            run_mul(xs[i], ys[i], lat, prod);
            n_cmp += 2;
            if (lat !== 5) begin n_bad++; $display("FAIL corner%0d_latency: got %0d want 5", i, lat); end
            if (prod !== ex[i]) begin n_bad++; $display("FAIL corner%0d_p: %h x %h got %h want %h", i, xs[i], ys[i], prod, ex[i]); end
        end
    endtask

    task automatic test_busy_reject();
        int n_done = 0;
        wait_idle();
        start = 1'b1;
        a = 8'h03;
        b = 8'h07;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_done += int'(done);
            case (k)
                1: start = 1'b0;
                2: begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
                3: start = 1'b0;
                5: begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
                6: start = 1'b0;
                default: ;
            endcase
        end
        n_cmp += 3;
        if (n_done !== 1) begin n_bad++; $display("FAIL reject_done_count: got %0d want 1", n_done); end
        if (p !== 16'h0015) begin n_bad++; $display("FAIL reject_p: got %h want 0015", p); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reject_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int n_done = 0;
        int c_bad = 0;
        wait_idle();
        start = 1'b1;
        a = 8'h21;
        b = 8'h02;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (dut.u_mul.c !== 1'b0) c_bad++;
            if (done) begin
                n_done++;
                n_cmp++;
                if (p !== 16'h0042) begin n_bad++; $display("FAIL b2b_p: got %h want 0042 at cycle %0d", p, k); end
                n_cmp++;
                if (k - last !== 6 && last >= 0) begin n_bad++; $display("FAIL b2b_interval: got %0d want 6", k - last); end
                else if (last < 0 && k !== 5) begin n_bad++; $display("FAIL b2b_first: got cycle %0d want 5", k); end
                last = k;
            end
        end
        start = 1'b0;
        n_cmp += 2;
        if (n_done !== 3) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
        if (c_bad !== 0) begin n_bad++; $display("FAIL b2b_mode_c: got %0d cycles with c!=0 want 0", c_bad); end
        wait_idle();
    endtask

    task automatic test_reset_midop();
        int n_done = 0;
        int lat;
        logic [15:0] prod;
        wait_idle();
        start = 1'b1;
        a = 8'h12;
        b = 8'h34;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_done += int'(done);
        end
        n_cmp += 2;
        if (n_done !== 0) begin n_bad++; $display("FAIL midrst_done_count: got %0d want 0", n_done); end
        if (p !== 16'h0000) begin n_bad++; $display("FAIL midrst_p: got %h want 0000", p); end
        run_mul(8'h05, 8'h05, lat, prod);
        n_cmp += 2;
        if (lat !== 5) begin n_bad++; $display("FAIL midrst_after_latency: got %0d want 5", lat); end
        if (prod !== 16'h0019) begin n_bad++; $display("FAIL midrst_after_p: got %h want 0019", prod); end
    endtask

    initial begin
        #12 rst = 1'b0;
        test_reset();
        test_basic();
        test_corners();
        test_busy_reject();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
